// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: datapath widths, opcodes and the DE/EX stage FSM states.
package lc3b_types;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned CNT_W  = 16;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [REG_W-1:0]  lc3b_reg;

    typedef enum logic [OPC_W-1:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_BUBBLE = 2'd1,
        ST_HOLD      = 2'd2
    } de_ex_state_e;

    localparam logic [CNT_W-1:0] BUBBLE_MAX = '1;

endpackage

// File: rtl/de_ex_stage_load_use_detect.sv
// Flags a decode instruction that reads the destination of a load currently in EX.
module load_use_detect
    import lc3b_types::*;
(
    input  logic    i_de_valid,
    input  lc3b_reg i_de_rs,
    input  lc3b_reg i_de_rt,
    input  logic    i_de_uses_rt,
    input  logic    i_ex_valid,
    input  logic    i_ex_mem_read,
    input  lc3b_reg i_ex_dr,
    output logic    o_lu_hazard_c
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_dr == i_de_rs);
    assign w_rt_match = i_de_uses_rt && (i_ex_dr == i_de_rt);

    // R0 as a destination never creates a dependency
    assign o_lu_hazard_c = i_de_valid && i_ex_valid && i_ex_mem_read
                        && (i_ex_dr != REG_W'(0)) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/de_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion, memory-stall hold and flush.
module de_ex_stage
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             de_valid,
    input  lc3b_word         de_pc,
    input  lc3b_opcode       de_opcode,
    input  lc3b_reg          de_rs,
    input  lc3b_reg          de_rt,
    input  lc3b_reg          de_dr,
    input  logic             de_uses_rt,
    input  lc3b_word         de_sr1_val,
    input  lc3b_word         de_sr2_val,
    input  logic             de_load_regfile,
    input  logic             de_mem_read,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             de_ex_valid,
    output lc3b_word         de_ex_pc,
    output lc3b_opcode       de_ex_opcode,
    output lc3b_word         de_ex_sr1,
    output lc3b_word         de_ex_sr2,
    output lc3b_reg          de_ex_rs_out,
    output lc3b_reg          de_ex_rt_out,
    output lc3b_reg          de_ex_dr_out,
    output logic             de_ex_load_regfile,
    output logic             de_ex_mem_read,
    output logic             stall_decode,
    output logic [CNT_W-1:0] bubble_count
);

    de_ex_state_e     r_state;
    de_ex_state_e     w_state_next;
    logic             w_lu_hazard;
    logic             w_advance;
    logic             w_bubble;
    logic             w_kill;
    logic             w_stall_c;

    logic             r_valid;
    lc3b_word         r_pc;
    lc3b_opcode       r_opcode;
    lc3b_word         r_sr1;
    lc3b_word         r_sr2;
    lc3b_reg          r_rs;
    lc3b_reg          r_rt;
    lc3b_reg          r_dr;
    logic             r_load_regfile;
    logic             r_mem_read;
    logic [CNT_W-1:0] r_bubble_count;

    load_use_detect u_load_use_detect (
        .i_de_valid    (de_valid),
        .i_de_rs       (de_rs),
        .i_de_rt       (de_rt),
        .i_de_uses_rt  (de_uses_rt),
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_mem_read),
        .i_ex_dr       (r_dr),
        .o_lu_hazard_c (w_lu_hazard)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Per-cycle priority: flush, then memory stall, then load-use bubble, then advance
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_bubble     = 1'b0;
        w_kill       = 1'b0;
        w_stall_c    = 1'b0;
        if (flush) begin
            w_kill       = 1'b1;
            w_state_next = ST_RUN;
        end else if (mem_stall) begin
            w_stall_c    = 1'b1;
            w_state_next = ST_HOLD;
        end else if (w_lu_hazard && (r_state != ST_LU_BUBBLE)) begin
            w_bubble     = 1'b1;
            w_stall_c    = 1'b1;
            w_state_next = ST_LU_BUBBLE;
        end else begin
            w_advance    = 1'b1;
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid        <= 1'b0;
            r_pc           <= '0;
            r_opcode       <= OP_BR;
            r_sr1          <= '0;
            r_sr2          <= '0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_dr           <= '0;
            r_load_regfile <= 1'b0;
            r_mem_read     <= 1'b0;
            r_bubble_count <= '0;
        end else begin
            if (w_advance) begin
                r_valid        <= de_valid;
                r_pc           <= de_pc;
                r_opcode       <= de_opcode;
                r_sr1          <= de_sr1_val;
                r_sr2          <= de_sr2_val;
                r_rs           <= de_rs;
                r_rt           <= de_rt;
                r_dr           <= de_dr;
                r_load_regfile <= de_valid & de_load_regfile;
                r_mem_read     <= de_valid & de_mem_read;
            end else if (w_kill || w_bubble) begin
                r_valid        <= 1'b0;
                r_load_regfile <= 1'b0;
                r_mem_read     <= 1'b0;
            end
            if (w_bubble && (r_bubble_count != BUBBLE_MAX)) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    assign stall_decode       = reset_n & w_stall_c;
    assign de_ex_valid        = r_valid;
    assign de_ex_pc           = r_pc;
    assign de_ex_opcode       = r_opcode;
    assign de_ex_sr1          = r_sr1;
    assign de_ex_sr2          = r_sr2;
    assign de_ex_rs_out       = r_rs;
    assign de_ex_rt_out       = r_rt;
    assign de_ex_dr_out       = r_dr;
    assign de_ex_load_regfile = r_load_regfile;
    assign de_ex_mem_read     = r_mem_read;
    assign bubble_count       = r_bubble_count;

endmodule

// File: tb/tb_de_ex_stage.sv
// Directed self-checking bench for de_ex_stage: load-use bubbles, stalls, flush, saturation, reset.
module tb_de_ex_stage;
    import lc3b_types::*;

    logic             clk;
    logic             reset_n;
    logic             de_valid;
    lc3b_word         de_pc;
    lc3b_opcode       de_opcode;
    lc3b_reg          de_rs;
    lc3b_reg          de_rt;
    lc3b_reg          de_dr;
    logic             de_uses_rt;
    lc3b_word         de_sr1_val;
    lc3b_word         de_sr2_val;
    logic             de_load_regfile;
    logic             de_mem_read;
    logic             mem_stall;
    logic             flush;
    logic             de_ex_valid;
    lc3b_word         de_ex_pc;
    lc3b_opcode       de_ex_opcode;
    lc3b_word         de_ex_sr1;
    lc3b_word         de_ex_sr2;
    lc3b_reg          de_ex_rs_out;
    lc3b_reg          de_ex_rt_out;
    lc3b_reg          de_ex_dr_out;
    logic             de_ex_load_regfile;
    logic             de_ex_mem_read;
    logic             stall_decode;
    logic [CNT_W-1:0] bubble_count;

    int n_checks = 0;
    int n_pass   = 0;

    de_ex_stage dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .de_valid           (de_valid),
        .de_pc              (de_pc),
        .de_opcode          (de_opcode),
        .de_rs              (de_rs),
        .de_rt              (de_rt),
        .de_dr              (de_dr),
        .de_uses_rt         (de_uses_rt),
        .de_sr1_val         (de_sr1_val),
        .de_sr2_val         (de_sr2_val),
        .de_load_regfile    (de_load_regfile),
        .de_mem_read        (de_mem_read),
        .mem_stall          (mem_stall),
        .flush              (flush),
        .de_ex_valid        (de_ex_valid),
        .de_ex_pc           (de_ex_pc),
        .de_ex_opcode       (de_ex_opcode),
        .de_ex_sr1          (de_ex_sr1),
        .de_ex_sr2          (de_ex_sr2),
        .de_ex_rs_out       (de_ex_rs_out),
        .de_ex_rt_out       (de_ex_rt_out),
        .de_ex_dr_out       (de_ex_dr_out),
        .de_ex_load_regfile (de_ex_load_regfile),
        .de_ex_mem_read     (de_ex_mem_read),
        .stall_decode       (stall_decode),
        .bubble_count       (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_de(input logic v, input lc3b_word pc, input lc3b_opcode op,
                            input lc3b_reg rs, input lc3b_reg rt, input lc3b_reg dr,
                            input logic uses_rt, input logic ld, input logic mr);
        de_valid        = v;
        de_pc           = pc;
        de_opcode       = op;
        de_rs           = rs;
        de_rt           = rt;
        de_dr           = dr;
        de_uses_rt      = uses_rt;
        de_sr1_val      = pc + 16'h1000;
        de_sr2_val      = ~pc;
        de_load_regfile = ld;
        de_mem_read     = mr;
    endtask

    task automatic ldr(input lc3b_reg dr, input lc3b_reg rs, input lc3b_word pc);
        drive_de(1'b1, pc, OP_LDR, rs, 3'd0, dr, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic add_r(input lc3b_reg dr, input lc3b_reg rs, input lc3b_reg rt, input lc3b_word pc);
        drive_de(1'b1, pc, OP_ADD, rs, rt, dr, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic add_i(input lc3b_reg dr, input lc3b_reg rs, input lc3b_reg rt, input lc3b_word pc);
        drive_de(1'b1, pc, OP_ADD, rs, rt, dr, 1'b0, 1'b1, 1'b0);
    endtask

    // One dependent LDR R7 -> ADD pair: exactly one bubble, ADD left in EX
    task automatic do_hazard(input lc3b_word pc);
        ldr(3'd7, 3'd1, pc);
        tick();
        add_r(3'd1, 3'd7, 3'd2, pc + 16'd2);
        tick();
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_stall = 1'b1;
        flush     = 1'b0;
        drive_de(1'b0, 16'h0000, OP_BR, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(de_ex_valid), 32'd0);
        check("rst_bubbles", 32'(bubble_count), 32'd0);
        check("rst_pc", 32'(de_ex_pc), 32'd0);
        check("rst_stall_decode", 32'(stall_decode), 32'd0);
        mem_stall = 1'b0;
        reset_n   = 1'b1;

        // LDR R3 then dependent ADD R1,R3,R2
        ldr(3'd3, 3'd2, 16'h3000);
        tick();
        check("ldr_valid", 32'(de_ex_valid), 32'd1);
        check("ldr_pc", 32'(de_ex_pc), 32'h3000);
        check("ldr_mem_read", 32'(de_ex_mem_read), 32'd1);
        check("ldr_dr", 32'(de_ex_dr_out), 32'd3);
        check("ldr_sr1", 32'(de_ex_sr1), 32'h4000);
        add_r(3'd1, 3'd3, 3'd2, 16'h3002);
        #1;
        check("lu_stall", 32'(stall_decode), 32'd1);
        tick();
        check("bubble_valid", 32'(de_ex_valid), 32'd0);
        check("bubble_mem_read", 32'(de_ex_mem_read), 32'd0);
        check("bubble_load_rf", 32'(de_ex_load_regfile), 32'd0);
        check("bubble_count_1", 32'(bubble_count), 32'd1);
        check("bubble_no_stall", 32'(stall_decode), 32'd0);
        tick();
        check("add_valid", 32'(de_ex_valid), 32'd1);
        check("add_pc", 32'(de_ex_pc), 32'h3002);
        check("add_opcode", 32'(de_ex_opcode), 32'(OP_ADD));
        check("add_rt", 32'(de_ex_rt_out), 32'd2);
        check("add_sr2", 32'(de_ex_sr2), 32'hCFFD);
        check("add_load_rf", 32'(de_ex_load_regfile), 32'd1);

        // LDR R0 never hazards; immediate form ignores rt
        ldr(3'd0, 3'd1, 16'h3004);
        tick();
        add_r(3'd1, 3'd0, 3'd0, 16'h3006);
        #1;
        check("r0_no_stall", 32'(stall_decode), 32'd0);
        tick();
        check("r0_add_pc", 32'(de_ex_pc), 32'h3006);
        ldr(3'd3, 3'd1, 16'h3008);
        tick();
        add_i(3'd2, 3'd1, 3'd3, 16'h300A);
        #1;
        check("imm_no_stall", 32'(stall_decode), 32'd0);
        tick();
        check("imm_add_pc", 32'(de_ex_pc), 32'h300A);
        check("imm_bubbles", 32'(bubble_count), 32'd1);

        // Back-to-back dependent loads: one bubble each
        ldr(3'd4, 3'd1, 16'h300C);
        tick();
        ldr(3'd5, 3'd4, 16'h300E);
        #1;
        check("b2b_stall_1", 32'(stall_decode), 32'd1);
        tick();
        check("b2b_bubble_1", 32'(de_ex_valid), 32'd0);
        tick();
        check("b2b_ldr5_pc", 32'(de_ex_pc), 32'h300E);
        check("b2b_ldr5_mr", 32'(de_ex_mem_read), 32'd1);
        add_r(3'd1, 3'd5, 3'd2, 16'h3010);
        #1;
        check("b2b_stall_2", 32'(stall_decode), 32'd1);
        tick();
        check("b2b_bubbles", 32'(bubble_count), 32'd3);
        tick();
        check("b2b_add_pc", 32'(de_ex_pc), 32'h3010);

        // Memory stall holds EX for three cycles, advance on the fourth
        add_r(3'd2, 3'd1, 3'd1, 16'h3012);
        mem_stall = 1'b1;
        #1;
        check("ms_stall_decode", 32'(stall_decode), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ms_hold_pc", 32'(de_ex_pc), 32'h3010);
            check("ms_hold_valid", 32'(de_ex_valid), 32'd1);
        end
        mem_stall = 1'b0;
        #1;
        check("ms_release_stall", 32'(stall_decode), 32'd0);
        tick();
        check("ms_advance_pc", 32'(de_ex_pc), 32'h3012);

        // Flush beats both mem_stall and a pending load-use hazard
        ldr(3'd6, 3'd1, 16'h3014);
        tick();
        add_r(3'd1, 3'd6, 3'd2, 16'h3016);
        mem_stall = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_stall_decode", 32'(stall_decode), 32'd0);
        tick();
        check("flush_valid", 32'(de_ex_valid), 32'd0);
        check("flush_mem_read", 32'(de_ex_mem_read), 32'd0);
        check("flush_bubbles", 32'(bubble_count), 32'd3);
        flush     = 1'b0;
        mem_stall = 1'b0;
        tick();
        check("flush_run_pc", 32'(de_ex_pc), 32'h3016);
        check("flush_run_valid", 32'(de_ex_valid), 32'd1);

        // Saturation from a preloaded count
        force dut.r_bubble_count = 16'hFFFC;
        #1;
        release dut.r_bubble_count;
        do_hazard(16'h3020);
        do_hazard(16'h3024);
        check("sat_fffe", 32'(bubble_count), 32'hFFFE);
        do_hazard(16'h3028);
        check("sat_ffff_a", 32'(bubble_count), 32'hFFFF);
        do_hazard(16'h302C);
        do_hazard(16'h3030);
        check("sat_ffff_b", 32'(bubble_count), 32'hFFFF);

        // Asynchronous reset while sitting in LU_BUBBLE
        ldr(3'd2, 3'd1, 16'h3100);
        tick();
        add_r(3'd4, 3'd2, 3'd3, 16'h3102);
        tick();
        check("pre_rst_bubble", 32'(de_ex_valid), 32'd0);
        #2;
        reset_n   = 1'b0;
        mem_stall = 1'b1;
        #1;
        check("arst_pc", 32'(de_ex_pc), 32'd0);
        check("arst_dr", 32'(de_ex_dr_out), 32'd0);
        check("arst_bubbles", 32'(bubble_count), 32'd0);
        check("arst_stall_decode", 32'(stall_decode), 32'd0);
        #2;
        mem_stall = 1'b0;
        reset_n   = 1'b1;
        tick();
        check("post_rst_valid", 32'(de_ex_valid), 32'd1);
        check("post_rst_pc", 32'(de_ex_pc), 32'h3102);
        check("post_rst_bubbles", 32'(bubble_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
